mux_4x1_bank: RTL and testbench
===============================

# mux_4x1_bank

Registered 4:1 selector for the memory-bank datapath. It picks one of four equal-width input lanes using a 2-bit select and presents the chosen lane on a registered output, with a companion valid flag. It sits between the four bank read-data paths and the port read-data register of the dual-port RAM.

## Interface
Parameters:
- `WIDTH`, default 1: bit width of each input lane and of `out`. Legal range is 1 to 1024.

Ports:
- `clk`, input, 1 bit: single clock. All state updates on the rising edge.
- `rst`, input, 1 bit: reset, synchronous and active-high.
- `en`, input, 1 bit: capture enable. When high, the selected lane is loaded on the next rising edge.
- `i0`, input, WIDTH bits: lane 0.
- `i1`, input, WIDTH bits: lane 1.
- `i2`, input, WIDTH bits: lane 2.
- `i3`, input, WIDTH bits: lane 3.
- `sel`, input, 2 bits: lane select. 00→i0, 01→i1, 10→i2, 11→i3.
- `out`, output, WIDTH bits: registered selected lane.
- `out_valid`, output, 1 bit: high for exactly the cycle after a capture.
- `sel_q`, output, 2 bits: the `sel` value that produced the current `out`.

## Operation
- Combinational select: `mux = sel==0 ? i0 : sel==1 ? i1 : sel==2 ? i2 : i3`. This is a full case; no value of `sel` is undefined.
- On each rising `clk`:
  - If `rst`: clear `out`, `out_valid` and `sel_q` to 0.
  - Else if `en`: load `out` from `mux`, set `out_valid` to 1, load `sel_q` from `sel`.
  - Else: `out` and `sel_q` hold their values; `out_valid` goes to 0.
- X or Z on `sel` must not corrupt state. Simulation assertion: `sel` has no X/Z whenever `en` is high.
- Values wider than WIDTH cannot reach the block; the integrator truncates to the LSBs.
- There is no state machine; the block is a single pipeline register stage.

## Timing
- Latency from `sel`/lane/`en` sampled at edge N to `out`/`out_valid` updated after edge N is 1 cycle.
- With `en` held high, throughput is one selection per cycle. Back-to-back `sel` changes give back-to-back outputs with no bubble.
- Reset values: `out`=0, `out_valid`=0, `sel_q`=0.
- Reset has priority over `en` when both are asserted in the same cycle.
- Reset asserted mid-stream clears the outputs at the next edge. The first capture after reset deasserts occurs at the first edge where `rst`=0 and `en`=1.
- Lane or `sel` changes while `en`=0 have no effect on the outputs.
- No combinational path exists from any input to any output.

## Structure
- A shared package holds:
  - `typedef logic [1:0] mux_sel_t`
  - localparams `SEL_I0`=0, `SEL_I1`=1, `SEL_I2`=2, `SEL_I3`=3
- One sub-module, `mux_4x1_comb`: a purely combinational WIDTH-parameterised selector with ports `i0`–`i3`, `sel` and `y`. The top level instantiates it and adds the register stage and assertions.
- `mux_4x1_comb` is reused unregistered elsewhere in the bank logic.

## Test plan
- **Reset:** with WIDTH=1, drive `rst`=1 for 2 cycles and `en`=1 with lanes all 1 → `out`=0, `out_valid`=0, `sel_q`=0. Release `rst` → `out`=i0 one cycle later.
- **Sweep, WIDTH=1:** lanes i0=0, i1=1, i2=0, i3=1, `en`=1, `sel` stepping 00, 01, 10, 11 per cycle → `out` = 0, 1, 0, 1, each one cycle after its `sel`, with `sel_q` tracking.
- **Sweep, WIDTH=8:** lanes 0x10, 0x11, 0x12, 0x13, same `sel` sweep → `out` = 0x10, 0x11, 0x12, 0x13. `out_valid` stays high throughout.
- **Hold:** capture `sel`=10 (0x12), then drop `en` and change `sel` to 11 and i2 to 0xFF → `out` stays 0x12, `sel_q` stays 10, `out_valid` is 0 from the next cycle.
- **Priority:** assert `rst` and `en` together with `sel`=01 → `out`=0, `out_valid`=0.
- **Reset mid-stream:** during the WIDTH=8 sweep, pulse `rst` on the `sel`=10 cycle → the next `out` is 0, then the sweep resumes with 0x13 on the following capture.

Source files
------------

// File: rtl/mux_4x1_bank_pkg.sv
// mux_4x1_bank_pkg
// Shared types and constants for the bank read-data selector.
//   mux_sel_t        : 2-bit lane select
//   SEL_I0..SEL_I3   : select encodings for lanes 0..3
package mux_4x1_bank_pkg;

  typedef logic [1:0] mux_sel_t;

  localparam mux_sel_t SEL_I0 = 2'd0;
  localparam mux_sel_t SEL_I1 = 2'd1;
  localparam mux_sel_t SEL_I2 = 2'd2;
  localparam mux_sel_t SEL_I3 = 2'd3;

endpackage

// File: rtl/mux_4x1_bank_if.sv
// mux_4x1_bank_if
// Groups the lane inputs, select, enable and registered outputs of the bank
// selector.
//   master : drives en, i0..i3, sel; observes out, out_valid, sel_q
//   slave  : the selector itself; the mirror of master
interface mux_4x1_bank_if #(parameter int WIDTH = 1);
  import mux_4x1_bank_pkg::*;

  logic             en;
  logic [WIDTH-1:0] i0;
  logic [WIDTH-1:0] i1;
  logic [WIDTH-1:0] i2;
  logic [WIDTH-1:0] i3;
  mux_sel_t         sel;
  logic [WIDTH-1:0] out;
  logic             out_valid;
  mux_sel_t         sel_q;

  modport master (
    output en, i0, i1, i2, i3, sel,
    input  out, out_valid, sel_q
  );

  modport slave (
    input  en, i0, i1, i2, i3, sel,
    output out, out_valid, sel_q
  );

endinterface

// File: rtl/mux_4x1_bank_comb.sv
// mux_4x1_comb
// Purely combinational 4:1 lane selector, also used unregistered elsewhere
// in the bank logic.
//   i0..i3 : WIDTH-bit input lanes
//   sel    : lane select (00 -> i0, 01 -> i1, 10 -> i2, 11 -> i3)
//   y      : selected lane
module mux_4x1_comb
  import mux_4x1_bank_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic [WIDTH-1:0] i0,
  input  logic [WIDTH-1:0] i1,
  input  logic [WIDTH-1:0] i2,
  input  logic [WIDTH-1:0] i3,
  input  mux_sel_t         sel,
  output logic [WIDTH-1:0] y
);

  // Every select value maps to a lane; lane 3 doubles as the default arm so
  // the selector is a full case and never infers a latch.
  always_comb begin
    y = i3;
    case (sel)
      SEL_I0:  y = i0;
      SEL_I1:  y = i1;
      SEL_I2:  y = i2;
      default: y = i3;
    endcase
  end

endmodule

// File: rtl/mux_4x1_bank.sv
// mux_4x1_bank
// Registered 4:1 selector between the four bank read-data paths and the port
// read-data register. One register stage, one cycle latency, no bubbles.
//   clk : rising-edge clock
//   rst : synchronous active-high reset (priority over en)
//   bus : slave side of mux_4x1_bank_if (en, i0..i3, sel in;
//         out, out_valid, sel_q out)
module mux_4x1_bank
  import mux_4x1_bank_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input logic            clk,
  input logic            rst,
  mux_4x1_bank_if.slave  bus
);

  logic [WIDTH-1:0] mux;

  mux_4x1_comb #(.WIDTH(WIDTH)) u_comb (
    .i0  (bus.i0),
    .i1  (bus.i1),
    .i2  (bus.i2),
    .i3  (bus.i3),
    .sel (bus.sel),
    .y   (mux)
  );

  // Output register: capture on en, otherwise hold data and select while the
  // valid flag drops, so out_valid marks only the cycle after a capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.out       <= '0;
      bus.out_valid <= 1'b0;
      bus.sel_q     <= SEL_I0;
    end else if (bus.en) begin
      bus.out       <= mux;
      bus.out_valid <= 1'b1;
      bus.sel_q     <= bus.sel;
    end else begin
      bus.out_valid <= 1'b0;
    end
  end

  // An unknown select while capturing would load garbage into the register.
  sel_known_on_en: assert property (@(posedge clk) bus.en |-> !$isunknown(bus.sel));

endmodule

// File: tb/tb_mux_4x1_bank.sv
// tb_mux_4x1_bank
// Directed bench for mux_4x1_bank: one WIDTH=1 instance and one WIDTH=8
// instance sharing a clock, each with its own reset and interface.
module tb_mux_4x1_bank;
  import mux_4x1_bank_pkg::*;

  logic clk;
  logic rst1;
  logic rst8;

  int testCount = 0;
  int failCount = 0;

  mux_4x1_bank_if #(.WIDTH(1)) nb ();
  mux_4x1_bank_if #(.WIDTH(8)) wb ();

  mux_4x1_bank #(.WIDTH(1)) dutNarrow (
    .clk (clk),
    .rst (rst1),
    .bus (nb.slave)
  );

  mux_4x1_bank #(.WIDTH(8)) dutWide (
    .clk (clk),
    .rst (rst8),
    .bus (wb.slave)
  );

  // 10-unit clock period
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive reset/enable/select for one instance, then advance one rising edge
  // and settle 1 unit past it so outputs are sampled away from the edge.
  task automatic applyStimulus(input logic isWide, input logic r, input logic e,
                               input mux_sel_t s);
    if (isWide) begin
      rst8   = r;
      wb.en  = e;
      wb.sel = s;
    end else begin
      rst1   = r;
      nb.en  = e;
      nb.sel = s;
    end
    @(posedge clk);
    #1;
  endtask

  // Compare out, out_valid and sel_q against hand-computed values.
  task automatic checkOutput(input string tag,
                             input logic [7:0] obsOut, input logic [7:0] expOut,
                             input logic obsValid, input logic expValid,
                             input mux_sel_t obsSel, input mux_sel_t expSel);
    testCount++;
    assert (obsOut === expOut) else begin
      failCount++;
      $error("[TB] FAIL %s.out observed=%h expected=%h", tag, obsOut, expOut);
    end
    testCount++;
    assert (obsValid === expValid) else begin
      failCount++;
      $error("[TB] FAIL %s.out_valid observed=%b expected=%b", tag, obsValid, expValid);
    end
    testCount++;
    assert (obsSel === expSel) else begin
      failCount++;
      $error("[TB] FAIL %s.sel_q observed=%b expected=%b", tag, obsSel, expSel);
    end
  endtask

  logic       narrowExp [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
  logic [7:0] wideExp   [4] = '{8'h10, 8'h11, 8'h12, 8'h13};

  initial begin
    rst1 = 1'b1;
    rst8 = 1'b1;
    nb.en = 1'b0; nb.sel = SEL_I0;
    nb.i0 = 1'b1; nb.i1 = 1'b1; nb.i2 = 1'b1; nb.i3 = 1'b1;
    wb.en = 1'b0; wb.sel = SEL_I0;
    wb.i0 = 8'h10; wb.i1 = 8'h11; wb.i2 = 8'h12; wb.i3 = 8'h13;

    // Reset held two cycles with en high and all lanes 1
    applyStimulus(1'b0, 1'b1, 1'b1, SEL_I0);
    applyStimulus(1'b0, 1'b1, 1'b1, SEL_I0);
    checkOutput("n_reset", {7'b0, nb.out}, 8'h00, nb.out_valid, 1'b0, nb.sel_q, SEL_I0);

    // First capture after release takes i0
    applyStimulus(1'b0, 1'b0, 1'b1, SEL_I0);
    checkOutput("n_release", {7'b0, nb.out}, 8'h01, nb.out_valid, 1'b1, nb.sel_q, SEL_I0);

    // WIDTH=1 sweep with alternating lanes
    nb.i0 = 1'b0; nb.i1 = 1'b1; nb.i2 = 1'b0; nb.i3 = 1'b1;
    for (int s = 0; s < 4; s++) begin
      applyStimulus(1'b0, 1'b0, 1'b1, mux_sel_t'(s));
      checkOutput($sformatf("n_sweep%0d", s), {7'b0, nb.out}, {7'b0, narrowExp[s]},
                  nb.out_valid, 1'b1, nb.sel_q, mux_sel_t'(s));
    end

    // Reset wins over a simultaneous capture of lane 1 (which is 1)
    applyStimulus(1'b0, 1'b1, 1'b1, SEL_I1);
    checkOutput("n_priority", {7'b0, nb.out}, 8'h00, nb.out_valid, 1'b0, nb.sel_q, SEL_I0);
    applyStimulus(1'b0, 1'b0, 1'b0, SEL_I0);

    // WIDTH=8 sweep, back-to-back with no bubble
    applyStimulus(1'b1, 1'b1, 1'b0, SEL_I0);
    checkOutput("w_reset", wb.out, 8'h00, wb.out_valid, 1'b0, wb.sel_q, SEL_I0);
    for (int s = 0; s < 4; s++) begin
      applyStimulus(1'b1, 1'b0, 1'b1, mux_sel_t'(s));
      checkOutput($sformatf("w_sweep%0d", s), wb.out, wideExp[s],
                  wb.out_valid, 1'b1, wb.sel_q, mux_sel_t'(s));
    end

    // Hold: capture lane 2, then disable and disturb sel and i2
    applyStimulus(1'b1, 1'b0, 1'b1, SEL_I2);
    checkOutput("w_capture2", wb.out, 8'h12, wb.out_valid, 1'b1, wb.sel_q, SEL_I2);
    wb.i2 = 8'hFF;
    applyStimulus(1'b1, 1'b0, 1'b0, SEL_I3);
    checkOutput("w_hold1", wb.out, 8'h12, wb.out_valid, 1'b0, wb.sel_q, SEL_I2);
    applyStimulus(1'b1, 1'b0, 1'b0, SEL_I3);
    checkOutput("w_hold2", wb.out, 8'h12, wb.out_valid, 1'b0, wb.sel_q, SEL_I2);
    wb.i2 = 8'h12;

    // Reset pulsed mid-sweep on the sel=10 cycle, then the sweep resumes
    applyStimulus(1'b1, 1'b0, 1'b1, SEL_I0);
    checkOutput("w_mid0", wb.out, 8'h10, wb.out_valid, 1'b1, wb.sel_q, SEL_I0);
    applyStimulus(1'b1, 1'b0, 1'b1, SEL_I1);
    checkOutput("w_mid1", wb.out, 8'h11, wb.out_valid, 1'b1, wb.sel_q, SEL_I1);
    applyStimulus(1'b1, 1'b1, 1'b1, SEL_I2);
    checkOutput("w_midrst", wb.out, 8'h00, wb.out_valid, 1'b0, wb.sel_q, SEL_I0);
    applyStimulus(1'b1, 1'b0, 1'b1, SEL_I3);
    checkOutput("w_mid3", wb.out, 8'h13, wb.out_valid, 1'b1, wb.sel_q, SEL_I3);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
